// File: rtl/decimator_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : decimator_pkg                                          |
// | Brief   : Shared types and sizing helpers for the filtering      |
// |           decimator (mode encoding, accumulator width).          |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package decimator_pkg;

    // Decimation behaviour selected by the 1-bit mode input
    typedef enum logic {
        DEC_AVERAGE = 1'b0,
        DEC_PICK    = 1'b1
    } dec_mode_e;

    // Summing 2^max_ratio_log2 full-scale samples grows the magnitude by
    // max_ratio_log2 bits, so this width can never overflow.
    function automatic int acc_width(input int data_width, input int max_ratio_log2);
        return data_width + max_ratio_log2;
    endfunction

endpackage : decimator_pkg
`default_nettype wire

// File: rtl/decimator_channel_state.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : decimator_channel_state                                |
// | Brief   : Per-channel sample counter and accumulator storage     |
// |           with one combinational read port and one write port.   |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module decimator_channel_state #(
    parameter int N_CHANNELS = 4,
    parameter int CNT_W      = 6,
    parameter int ACC_W      = 22,
    parameter int IDX_W      = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear_all,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [CNT_W-1:0]        rd_cnt,
    output logic signed [ACC_W-1:0] rd_acc,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [CNT_W-1:0]        wr_cnt,
    input  logic signed [ACC_W-1:0] wr_acc
);

    logic [CNT_W-1:0]        cnt_q [N_CHANNELS];
    logic [CNT_W-1:0]        cnt_d [N_CHANNELS];
    logic signed [ACC_W-1:0] acc_q [N_CHANNELS];
    logic signed [ACC_W-1:0] acc_d [N_CHANNELS];

    // Read port: out-of-range indices read as an empty channel
    always_comb begin
        rd_cnt = '0;
        rd_acc = '0;
        if (int'(rd_idx) < N_CHANNELS) begin
            rd_cnt = cnt_q[rd_idx];
            rd_acc = acc_q[rd_idx];
        end
    end

    // Next state: a global clear first, then the single-channel write on top
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (clear_all) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                cnt_d[i] = '0;
                acc_d[i] = '0;
            end
        end
        if (wr_en && (int'(wr_idx) < N_CHANNELS)) begin
            cnt_d[wr_idx] = wr_cnt;
            acc_d[wr_idx] = wr_acc;
        end
    end

    // State array registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                cnt_q[i] <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule : decimator_channel_state
`default_nettype wire

// File: rtl/filtering_decimator_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : filtering_decimator_mc                                 |
// | Brief   : Multi-channel power-of-two decimator, AXI-stream in    |
// |           and out; averages (integrate-and-dump) or picks every  |
// |           R-th sample per interleaved channel.                   |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module filtering_decimator_mc
    import decimator_pkg::*;
#(
    parameter  int DATA_WIDTH     = 16,
    parameter  int N_CHANNELS     = 4,
    parameter  int MAX_RATIO_LOG2 = 6,
    localparam int RATIO_W        = $clog2(MAX_RATIO_LOG2 + 1),
    localparam int DEST_W         = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [RATIO_W-1:0]           ratio_log2,
    input  logic                         mode,
    input  logic signed [DATA_WIDTH-1:0] data_in_tdata,
    input  logic [DEST_W-1:0]            data_in_tdest,
    input  logic                         data_in_tvalid,
    output logic                         data_in_tready,
    output logic signed [DATA_WIDTH-1:0] data_out_tdata,
    output logic [DEST_W-1:0]            data_out_tdest,
    output logic                         data_out_tvalid,
    input  logic                         data_out_tready
);

    localparam int ACC_W = acc_width(DATA_WIDTH, MAX_RATIO_LOG2);
    localparam int CNT_W = MAX_RATIO_LOG2;

    // Registered configuration, compared against the live inputs
    logic [RATIO_W-1:0]           cfg_ratio_q, cfg_ratio_d;
    logic                         cfg_mode_q,  cfg_mode_d;
    // Output register
    logic                         out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [DEST_W-1:0]            out_dest_q,  out_dest_d;

    dec_mode_e                    mode_e;
    logic [RATIO_W-1:0]           ratio_eff;
    logic [CNT_W:0]               ratio_full;
    logic [CNT_W-1:0]             term_cnt;
    logic                         cfg_changed;
    logic                         xfer;
    logic                         dest_ok;
    logic                         last;
    logic [CNT_W-1:0]             rd_cnt, base_cnt, wr_cnt;
    logic signed [ACC_W-1:0]      rd_acc, base_acc, wr_acc;
    logic signed [ACC_W-1:0]      sample_ext, sum_acc, sum_shift;
    logic signed [DATA_WIDTH-1:0] result;
    logic                         wr_en;
    logic                         emit;

    // Decode config, compute the read-modify-write update for the addressed channel
    always_comb begin
        mode_e      = dec_mode_e'(mode);
        ratio_eff   = (int'(ratio_log2) > MAX_RATIO_LOG2) ? RATIO_W'(MAX_RATIO_LOG2) : ratio_log2;
        ratio_full  = (CNT_W + 1)'(1) << ratio_eff;
        term_cnt    = CNT_W'(ratio_full - (CNT_W + 1)'(1));
        // A config change wipes all channels this cycle; a sample arriving in the
        // same cycle is counted as the first one under the new config.
        cfg_changed = (ratio_log2 != cfg_ratio_q) || (mode != cfg_mode_q);
        cfg_ratio_d = ratio_log2;
        cfg_mode_d  = mode;

        data_in_tready = !reset && (!out_valid_q || data_out_tready);
        xfer       = data_in_tvalid && data_in_tready;
        dest_ok    = int'(data_in_tdest) < N_CHANNELS;

        base_cnt   = cfg_changed ? '0 : rd_cnt;
        base_acc   = cfg_changed ? '0 : rd_acc;
        last       = (base_cnt == term_cnt);
        sample_ext = {{MAX_RATIO_LOG2{data_in_tdata[DATA_WIDTH-1]}}, data_in_tdata};
        sum_acc    = base_acc + sample_ext;
        sum_shift  = sum_acc >>> ratio_eff;
        result     = (mode_e == DEC_PICK) ? data_in_tdata : sum_shift[DATA_WIDTH-1:0];

        wr_en      = xfer && dest_ok;
        wr_cnt     = last ? '0 : base_cnt + CNT_W'(1);
        // Pick mode never accumulates, so the sum stays at zero there
        wr_acc     = (last || (mode_e == DEC_PICK)) ? '0 : sum_acc;
        emit       = wr_en && last;
    end

    // Output register: load on emission, drop valid on consumption, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_dest_d  = out_dest_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
            out_dest_d  = data_in_tdest;
        end else if (data_out_tready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output and configuration registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_dest_q  <= '0;
            cfg_ratio_q <= '0;
            cfg_mode_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_dest_q  <= out_dest_d;
            cfg_ratio_q <= cfg_ratio_d;
            cfg_mode_q  <= cfg_mode_d;
        end
    end

    assign data_out_tvalid = out_valid_q;
    assign data_out_tdata  = out_data_q;
    assign data_out_tdest  = out_dest_q;

    decimator_channel_state #(
        .N_CHANNELS (N_CHANNELS),
        .CNT_W      (CNT_W),
        .ACC_W      (ACC_W),
        .IDX_W      (DEST_W)
    ) u_state (
        .clock     (clock),
        .reset     (reset),
        .clear_all (cfg_changed),
        .rd_idx    (data_in_tdest),
        .rd_cnt    (rd_cnt),
        .rd_acc    (rd_acc),
        .wr_en     (wr_en),
        .wr_idx    (data_in_tdest),
        .wr_cnt    (wr_cnt),
        .wr_acc    (wr_acc)
    );

endmodule : filtering_decimator_mc
`default_nettype wire

// File: tb/tb_filtering_decimator_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_filtering_decimator_mc                              |
// | Brief   : Self-checking bench; two instances (4 and 3 channels)  |
// |           share stimulus and are compared each cycle against a   |
// |           per-channel sum/count reference model.                 |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_filtering_decimator_mc;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [2:0]         ratio_log2 = '0;
    logic               mode = 1'b0;
    logic signed [15:0] in_data = '0;
    logic [1:0]         in_dest = '0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b1;

    logic               rdy0, rdy1, ov0, ov1;
    logic signed [15:0] od0, od1;
    logic [1:0]         dst0, dst1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    filtering_decimator_mc #(.DATA_WIDTH(16), .N_CHANNELS(4), .MAX_RATIO_LOG2(6)) dut0 (
        .clock(clock), .reset(reset), .ratio_log2(ratio_log2), .mode(mode),
        .data_in_tdata(in_data), .data_in_tdest(in_dest), .data_in_tvalid(in_valid),
        .data_in_tready(rdy0), .data_out_tdata(od0), .data_out_tdest(dst0),
        .data_out_tvalid(ov0), .data_out_tready(out_ready));

    filtering_decimator_mc #(.DATA_WIDTH(16), .N_CHANNELS(3), .MAX_RATIO_LOG2(6)) dut1 (
        .clock(clock), .reset(reset), .ratio_log2(ratio_log2), .mode(mode),
        .data_in_tdata(in_data), .data_in_tdest(in_dest), .data_in_tvalid(in_valid),
        .data_in_tready(rdy1), .data_out_tdata(od1), .data_out_tdest(dst1),
        .data_out_tvalid(ov1), .data_out_tready(out_ready));

    // Reference model: per instance, per channel, a count of accepted samples and their plain sum
    int     m_cnt [2][16];
    longint m_sum [2][16];
    bit     m_vld [2];
    longint m_dat [2];
    int     m_dst [2];
    int     p_ratio;
    bit     p_mode;

    function automatic int nch(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 16; c++) begin
                m_cnt[k][c] = 0;
                m_sum[k][c] = 0;
            end
            m_vld[k] = 0; m_dat[k] = 0; m_dst[k] = 0;
        end
        p_ratio = 0; p_mode = 0;
    endtask

    task automatic model_step();
        int reff, rr, c;
        bit chg, emit, rdy;
        longint val;
        if (reset) begin
            model_reset();
            return;
        end
        reff = (int'(ratio_log2) > 6) ? 6 : int'(ratio_log2);
        rr   = 1 << reff;
        chg  = (int'(ratio_log2) != p_ratio) || (mode != p_mode);
        p_ratio = int'(ratio_log2);
        p_mode  = mode;
        c    = int'(in_dest);
        for (int k = 0; k < 2; k++) begin
            rdy  = !m_vld[k] || out_ready;
            emit = 0;
            val  = 0;
            if (chg) begin
                for (int j = 0; j < 16; j++) begin
                    m_cnt[k][j] = 0;
                    m_sum[k][j] = 0;
                end
            end
            if (in_valid && rdy && c < nch(k)) begin
                m_cnt[k][c] = m_cnt[k][c] + 1;
                if (!mode) m_sum[k][c] = m_sum[k][c] + longint'(in_data);
                if (m_cnt[k][c] == rr) begin
                    emit = 1;
                    val  = mode ? longint'(in_data) : (m_sum[k][c] >>> reff);
                    m_cnt[k][c] = 0;
                    m_sum[k][c] = 0;
                end
            end
            if (emit) begin
                m_vld[k] = 1; m_dat[k] = val; m_dst[k] = c;
            end else if (out_ready) begin
                m_vld[k] = 0;
            end
        end
    endtask

    // One clock: check tready mid-cycle, advance model at the edge, check outputs just after
    task automatic step();
        @(negedge clock);
        chk("in_tready0", rdy0, (!reset && (!m_vld[0] || out_ready)) ? 1 : 0);
        chk("in_tready1", rdy1, (!reset && (!m_vld[1] || out_ready)) ? 1 : 0);
        @(posedge clock);
        model_step();
        #1;
        chk("out_valid0", ov0, m_vld[0]);
        chk("out_valid1", ov1, m_vld[1]);
        if (m_vld[0]) begin
            chk("out_data0", od0, m_dat[0]);
            chk("out_dest0", dst0, m_dst[0]);
        end
        if (m_vld[1]) begin
            chk("out_data1", od1, m_dat[1]);
            chk("out_dest1", dst1, m_dst[1]);
        end
    endtask

    task automatic drive(input int v, input int d, input int x);
        in_valid = (v != 0);
        in_dest  = 2'(d);
        in_data  = 16'(x);
    endtask

    task automatic do_reset();
        drive(0, 0, 0);
        reset = 1'b1;
        #1;
        chk("rst_async_valid0", ov0, 0);
        chk("rst_async_data0",  od0, 0);
        chk("rst_async_dest0",  dst0, 0);
        chk("rst_async_valid1", ov1, 0);
        model_reset();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        int v, d, x, r, m, ot;
        int ev, ed, edst;
    } vec_t;

    vec_t tbl [16];
    int   ratios [8];
    int   n_out;

    initial begin
        // Average R=4; average R=2 with negative floor; pick R=2 round robin
        tbl[0]  = '{1, 0,  10, 2, 0, 1, 0,  0, 0};
        tbl[1]  = '{1, 0,  20, 2, 0, 1, 0,  0, 0};
        tbl[2]  = '{1, 0,  30, 2, 0, 1, 0,  0, 0};
        tbl[3]  = '{1, 0,  40, 2, 0, 1, 1, 25, 0};
        tbl[4]  = '{0, 0,   0, 2, 0, 1, 0,  0, 0};
        tbl[5]  = '{1, 0,  -3, 1, 0, 1, 0,  0, 0};
        tbl[6]  = '{1, 0,  -2, 1, 0, 1, 1, -3, 0};
        tbl[7]  = '{1, 0,   1, 1, 1, 1, 0,  0, 0};
        tbl[8]  = '{1, 1,   2, 1, 1, 1, 0,  0, 0};
        tbl[9]  = '{1, 2,   3, 1, 1, 1, 0,  0, 0};
        tbl[10] = '{1, 3,   4, 1, 1, 1, 0,  0, 0};
        tbl[11] = '{1, 0,   5, 1, 1, 1, 1,  5, 0};
        tbl[12] = '{1, 1,   6, 1, 1, 1, 1,  6, 1};
        tbl[13] = '{1, 2,   7, 1, 1, 1, 1,  7, 2};
        tbl[14] = '{1, 3,   8, 1, 1, 1, 1,  8, 3};
        tbl[15] = '{0, 0,   0, 1, 1, 1, 0,  0, 0};
        ratios  = '{0, 2, 7, 1, 3, 5, 4, 6};

        // Reset state, checked asynchronously before any clock edge
        #1;
        chk("reset_valid", ov0, 0);
        chk("reset_data",  od0, 0);
        chk("reset_dest",  dst0, 0);
        chk("reset_ready", rdy0, 0);
        model_reset();
        step();
        step();
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].x);
            ratio_log2 = 3'(tbl[i].r);
            mode       = (tbl[i].m != 0);
            out_ready  = (tbl[i].ot != 0);
            step();
            chk($sformatf("tbl%0d_valid", i), ov0, tbl[i].ev);
            if (tbl[i].ev != 0) begin
                chk($sformatf("tbl%0d_data", i), od0, tbl[i].ed);
                chk($sformatf("tbl%0d_dest", i), dst0, tbl[i].edst);
            end
        end

        // Backpressure with R=1: first output held while tready is low, then replaced
        ratio_log2 = 3'd0; mode = 1'b0; out_ready = 1'b0;
        drive(1, 0, 111);
        step();
        chk("bp_first", od0, 111);
        drive(1, 0, 222);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ready_low", rdy0, 0);
            chk("bp_hold_data", od0, 111);
            chk("bp_hold_valid", ov0, 1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_replace_valid", ov0, 1);
        chk("bp_replace_data", od0, 222);
        drive(0, 0, 0);
        step();
        chk("bp_drain_valid", ov0, 0);

        // Reset mid-accumulation discards the partial sum on channel 1
        ratio_log2 = 3'd3; mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 7);
            step();
        end
        do_reset();
        n_out = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 100);
            step();
            if (ov0) n_out++;
        end
        chk("rst_mid_count", n_out, 1);
        chk("rst_mid_data", od0, 100);
        chk("rst_mid_dest", dst0, 1);
        drive(0, 0, 0);
        step();

        // Full-scale averages at the maximum ratio
        ratio_log2 = 3'd6;
        for (int i = 0; i < 64; i++) begin
            drive(1, 2, -32768);
            step();
        end
        chk("fs_neg", od0, -32768);
        for (int i = 0; i < 64; i++) begin
            drive(1, 2, 32767);
            step();
        end
        chk("fs_pos", od0, 32767);

        // Randomized traffic, including tdest=3 (invalid for the 3-channel instance)
        for (int seg = 0; seg < 8; seg++) begin
            ratio_log2 = 3'(ratios[seg]);
            mode       = (seg % 3 == 1);
            for (int i = 0; i < 400; i++) begin
                if (seg == 3 && i == 200) ratio_log2 = 3'd1;
                if (seg == 5 && i == 150) do_reset();
                case ($urandom_range(0, 7))
                    0:       in_data = 16'sh8000;
                    1:       in_data = 16'sh7fff;
                    default: in_data = 16'($urandom);
                endcase
                in_valid  = ($urandom_range(0, 4) != 0);
                in_dest   = 2'($urandom_range(0, 3));
                out_ready = ($urandom_range(0, 4) != 0);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_filtering_decimator_mc
`default_nettype wire

// File: doc/filtering_decimator_mc.md
FILTERING_DECIMATOR_MC -- requirements
Module: filtering_decimator_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed sample width in and out.
REQ-002 Parameter N_CHANNELS, default 4, number of interleaved channels; range 1..16.
REQ-003 Parameter MAX_RATIO_LOG2, default 6, maximum decimation ratio exponent (ratio up to 64).
REQ-004 clock  in  1  single clock for all logic.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ratio_log2  in  $clog2(MAX_RATIO_LOG2+1)  decimation ratio R = 2^ratio_log2.
REQ-007 mode  in  1  0 = average (integrate-and-dump), 1 = pick (pass every R-th sample).
REQ-008 data_in_tdata  in  DATA_WIDTH  signed input sample.
REQ-009 data_in_tdest  in  $clog2(N_CHANNELS) (min 1)  channel index of the sample.
REQ-010 data_in_tvalid  in  1; data_in_tready  out  1  AXI-stream input handshake.
REQ-011 data_out_tdata  out  DATA_WIDTH  signed decimated sample.
REQ-012 data_out_tdest  out  as data_in_tdest  channel index of the output sample.
REQ-013 data_out_tvalid  out  1; data_out_tready  in  1  AXI-stream output handshake.

Function
REQ-014 Per channel, hold a sample counter (MAX_RATIO_LOG2 bits) and an accumulator (DATA_WIDTH+MAX_RATIO_LOG2 bits, signed).
REQ-015 Input transfer occurs when data_in_tvalid and data_in_tready are both high; data_in_tready = !data_out_tvalid || data_out_tready.
REQ-016 Average mode: on transfer add the sign-extended sample to the channel accumulator; on the R-th sample emit (accumulator + sample) >>> ratio_log2 (arithmetic shift, floor), then clear accumulator and counter.
REQ-017 Pick mode: on the R-th transfer of a channel emit that sample unmodified; accumulators unused and held at zero.
REQ-018 ratio_log2 = 0: every accepted sample is emitted unchanged in both modes.
REQ-019 Latency: data_out_tvalid rises the cycle after the R-th transfer; data_out_tdest equals the source channel.
REQ-020 Output register holds tdata/tdest stable while data_out_tvalid && !data_out_tready; data_out_tvalid clears on handshake unless a new output is produced in the same cycle.
REQ-021 Emission and consumption in the same cycle: new output replaces old, data_out_tvalid stays high, no sample lost.
REQ-022 Sample with data_in_tdest >= N_CHANNELS: accepted, discarded, no state change.
REQ-023 ratio_log2 > MAX_RATIO_LOG2: clamped to MAX_RATIO_LOG2.
REQ-024 Any change of ratio_log2 or mode (registered compare) clears all counters and accumulators the next cycle; a pending output is unaffected.
REQ-025 Accumulator width guarantees no overflow at R = 2^MAX_RATIO_LOG2 with full-scale inputs.

Reset
REQ-026 reset asserted: all counters and accumulators to 0, data_out_tvalid = 0, data_out_tdata = 0, data_out_tdest = 0, immediately and asynchronously.
REQ-027 Reset mid-accumulation discards partial sums; first output after reset needs a full R samples per channel.
REQ-028 data_in_tready = 0 while reset is high, 1 in the first cycle after release.

Structure
REQ-029 Package decimator_pkg holds the mode enum (DEC_AVERAGE, DEC_PICK) and the accumulator-width function.
REQ-030 One sub-module, decimator_channel_state: per-channel counter/accumulator array with read-modify-write port indexed by tdest.
REQ-031 No DSP primitive instantiation; inference only.

Verification
REQ-032 Avg, N=1, R=4, inputs 10,20,30,40 -> one output 25, tdest 0, valid one cycle after 4th transfer.
REQ-033 Avg, R=2, inputs -3,-2 -> output -3 (floor of -2.5).
REQ-034 Pick, N=4, R=2, round-robin ch0..3 values 1..8 -> outputs 5,6,7,8 with tdest 0,1,2,3.
REQ-035 Avg, R=1, data_out_tready held low 5 cycles -> data_in_tready low, first output held stable, no loss after release.
REQ-036 Avg, R=8, 3 samples on ch1, reset pulse mid-stream, then 8 samples of 100 -> single output 100.
REQ-037 Sample with tdest = N_CHANNELS during accumulation -> ignored, next outputs unchanged vs reference model.
